round_pack: RTL and testbench

//  Final stage of the FP add/mul datapath; sits directly downstream of normalize.

---
 rtl/round_pack_pkg.sv | 14 +
 rtl/round_pack_rne.sv | 19 +
 rtl/round_pack.sv | 150 +++++++++++++++
 tb/tb_round_pack.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/round_pack_pkg.sv
// Shared encodings and constants for the round/pack stage of the FP datapath.
package round_pack_pkg;

    typedef enum logic [1:0] {
        SPC_NORM = 2'b00,
        SPC_ZERO = 2'b01,
        SPC_INF  = 2'b10,
        SPC_NAN  = 2'b11
    } special_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_MAX = 8'hFF;

endpackage

// File: rtl/round_pack_rne.sv
// Round-to-nearest-even on a (mantissa, guard, sticky) triple; purely combinational.
module round_nearest_even #(
    parameter int SIZE_M = 24
) (
    input  logic [SIZE_M-1:0] m,
    input  logic              g,
    input  logic              s,
    output logic [SIZE_M:0]   sum,
    output logic              inexact
);

    logic inc_s;

    // Round up above the halfway point, or exactly at it when M is odd.
    assign inc_s   = g & (s | m[0]);
    assign sum     = {1'b0, m} + {{SIZE_M{1'b0}}, inc_s};
    assign inexact = g | s;

endmodule

// File: rtl/round_pack.sv
// Two-stage valid/ready pipeline: round to nearest-even, renormalize, saturate and pack.
module round_pack
    import round_pack_pkg::*;
#(
    parameter  int SIZE_MANTIS = 26,
    parameter  int SIZE_EXP    = 8,
    localparam int SIZE_FRAC   = SIZE_MANTIS - 3,
    localparam int W           = 1 + SIZE_EXP + SIZE_FRAC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign_in,
    input  logic [SIZE_EXP-1:0]    exp_in,
    input  logic [SIZE_MANTIS-1:0] mantis_in,
    input  logic [1:0]             special_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           result,
    output logic [2:0]             flags
);

    localparam int                SIZE_M  = SIZE_MANTIS - 2;
    localparam logic [SIZE_EXP:0] EXP_SAT = (SIZE_EXP + 1)'(EXP_MAX);
    localparam logic [W-1:0]      QNAN_W  = W'(QNAN);

    logic                 s1_adv_s;
    logic                 in_ready_s;
    logic [SIZE_M:0]      rne_sum_s;
    logic                 rne_inexact_s;

    logic                 s1_valid_r;
    logic                 s1_sign_r;
    logic [SIZE_EXP-1:0]  s1_exp_r;
    special_t             s1_special_r;
    logic [SIZE_M:0]      s1_sum_r;
    logic                 s1_inexact_r;
    logic                 s1_mzero_r;

    logic [SIZE_EXP:0]    exp_wide_s;
    logic [SIZE_FRAC-1:0] frac_s;
    logic [W-1:0]         pack_result_s;
    logic [2:0]           pack_flags_s;

    logic                 s2_valid_r;
    logic [W-1:0]         result_r;
    logic [2:0]           flags_r;

    assign s1_adv_s   = !s2_valid_r || out_ready;
    assign in_ready_s = !s1_valid_r || s1_adv_s;

    round_nearest_even #(
        .SIZE_M (SIZE_M)
    ) u_rne (
        .m       (mantis_in[SIZE_MANTIS-1:2]),
        .g       (mantis_in[1]),
        .s       (mantis_in[0]),
        .sum     (rne_sum_s),
        .inexact (rne_inexact_s)
    );

    // Stage 1: capture the rounded sum and the fields needed for packing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_sign_r    <= 1'b0;
            s1_exp_r     <= {SIZE_EXP{1'b0}};
            s1_special_r <= SPC_NORM;
            s1_sum_r     <= {(SIZE_M + 1){1'b0}};
            s1_inexact_r <= 1'b0;
            s1_mzero_r   <= 1'b0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= in_valid;
            end
            if (in_valid && in_ready_s) begin
                s1_sign_r    <= sign_in;
                s1_exp_r     <= exp_in;
                s1_special_r <= special_t'(special_in);
                s1_sum_r     <= rne_sum_s;
                s1_inexact_r <= rne_inexact_s;
                s1_mzero_r   <= (mantis_in == {SIZE_MANTIS{1'b0}});
            end
        end
    end

    // Exponent adjust and packing; carry-out takes priority over the subnormal promotion rule.
    always_comb begin
        exp_wide_s    = {1'b0, s1_exp_r};
        frac_s        = {SIZE_FRAC{1'b0}};
        pack_result_s = {W{1'b0}};
        pack_flags_s  = 3'b000;

        if (s1_sum_r[SIZE_M]) begin
            exp_wide_s = {1'b0, s1_exp_r} + (SIZE_EXP + 1)'(1);
            frac_s     = {SIZE_FRAC{1'b0}};
        end else if (s1_exp_r == {SIZE_EXP{1'b0}}) begin
            exp_wide_s = {{SIZE_EXP{1'b0}}, s1_sum_r[SIZE_M-1]};
            frac_s     = s1_sum_r[SIZE_FRAC-1:0];
        end else begin
            exp_wide_s = {1'b0, s1_exp_r};
            frac_s     = s1_sum_r[SIZE_FRAC-1:0];
        end

        case (s1_special_r)
            SPC_ZERO: pack_result_s = {s1_sign_r, {(W - 1){1'b0}}};
            SPC_INF:  pack_result_s = {s1_sign_r, {SIZE_EXP{1'b1}}, {SIZE_FRAC{1'b0}}};
            SPC_NAN:  pack_result_s = QNAN_W;
            SPC_NORM: begin
                if (s1_mzero_r) begin
                    pack_result_s = {s1_sign_r, {(W - 1){1'b0}}};
                end else if (exp_wide_s >= EXP_SAT) begin
                    pack_result_s = {s1_sign_r, {SIZE_EXP{1'b1}}, {SIZE_FRAC{1'b0}}};
                    pack_flags_s  = 3'b101;
                end else begin
                    pack_result_s = {s1_sign_r, exp_wide_s[SIZE_EXP-1:0], frac_s};
                    pack_flags_s  = {1'b0,
                                     (exp_wide_s[SIZE_EXP-1:0] == {SIZE_EXP{1'b0}}) && s1_inexact_r,
                                     s1_inexact_r};
                end
            end
            default: begin
                pack_result_s = QNAN_W;
                pack_flags_s  = 3'b000;
            end
        endcase
    end

    // Stage 2: output register, frozen while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            result_r   <= {W{1'b0}};
            flags_r    <= 3'b000;
        end else if (s1_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= pack_result_s;
                flags_r  <= pack_flags_s;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;

endmodule

// File: tb/tb_round_pack.sv
// Self-checking bench for round_pack: directed spec vectors, randomized scoreboard, stalls, reset.
module tb_round_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [25:0] mantis_in;
    logic [1:0]  special_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;
    logic [34:0] exp_q[$];

    round_pack dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sign_in    (sign_in),
        .exp_in     (exp_in),
        .mantis_in  (mantis_in),
        .special_in (special_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: value-level rounding of mantis/4 with remainder, then IEEE field packing.
    function automatic logic [34:0] model(input logic sgn, input logic [7:0] e,
                                          input logic [25:0] m, input logic [1:0] sp);
        int unsigned sig;
        int unsigned rem;
        int unsigned ex;
        logic        inex;
        logic [7:0]  field;
        logic [22:0] frac;
        if (sp == 2'd1) return {sgn, 31'd0, 3'd0};
        if (sp == 2'd2) return {sgn, 8'hFF, 23'd0, 3'd0};
        if (sp == 2'd3) return {32'h7FC00000, 3'd0};
        if (m == 26'd0) return {sgn, 31'd0, 3'd0};
        sig  = m / 4;
        rem  = m % 4;
        inex = (rem != 0);
        if (rem > 2 || (rem == 2 && sig % 2 == 1)) sig = sig + 1;
        if (sig >= 32'h0100_0000) begin
            sig = sig / 2;
            ex  = e + 1;
        end else if (e == 8'd0) begin
            ex = (sig >= 32'h0080_0000) ? 1 : 0;
        end else begin
            ex = e;
        end
        if (ex >= 255) return {sgn, 8'hFF, 23'd0, 3'b101};
        field = ex[7:0];
        frac  = sig[22:0];
        return {sgn, field, frac, 1'b0, (field == 8'd0) && inex, inex};
    endfunction

    task automatic idle_inputs();
        in_valid   = 1'b0;
        sign_in    = 1'b0;
        exp_in     = 8'd0;
        mantis_in  = 26'd0;
        special_in = 2'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
        n_checks++;
        if (flags !== 3'd0) begin n_fail++; $display("FAIL reset_flags: got %b want 000", flags); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic        v_sgn [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]  v_exp [11] = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd254, 8'd0, 8'd0, 8'd100, 8'd100, 8'd50, 8'd0};
        logic [25:0] v_man [11] = '{26'h2000000, 26'h2000002, 26'h2000006, 26'h3FFFFFE, 26'h3FFFFFE,
                                    26'h1FFFFFE, 26'h0, 26'h0, 26'h1234567, 26'h0, 26'h0000005};
        logic [1:0]  v_spc [11] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        logic [31:0] v_res [11] = '{32'h3F800000, 32'h3F800000, 32'h3F800002, 32'h40000000, 32'h7F800000,
                                    32'h00800000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h80000000,
                                    32'h00000001};
        logic [2:0]  v_flg [11] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b101, 3'b001, 3'b000, 3'b000,
                                    3'b000, 3'b000, 3'b011};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            sign_in    = v_sgn[i];
            exp_in     = v_exp[i];
            mantis_in  = v_man[i];
            special_in = v_spc[i];
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
            @(negedge clk);
            idle_inputs();
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL dir%0d_early_valid: got %b want 0", i, out_valid); end
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency: got %b want 1", i, out_valid); end
            n_checks++;
            if (result !== v_res[i]) begin n_fail++; $display("FAIL dir%0d_result: got %h want %h", i, result, v_res[i]); end
            n_checks++;
            if (flags !== v_flg[i]) begin n_fail++; $display("FAIL dir%0d_flags: got %b want %b", i, flags, v_flg[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [34:0] e;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            r        = $urandom;
            in_valid = (r[1:0] != 2'b00);
            sign_in  = r[2];
            r        = $urandom;
            case (r[2:0])
                3'd0:    exp_in = 8'd0;
                3'd1:    exp_in = 8'd254;
                3'd2:    exp_in = 8'd255;
                3'd3:    exp_in = 8'd1;
                default: exp_in = r[15:8];
            endcase
            r = $urandom;
            case (r[29:27])
                3'd0:    mantis_in = 26'h3FFFFFE;
                3'd1:    mantis_in = {r[25:2], 2'b10};
                3'd2:    mantis_in = 26'd0;
                default: mantis_in = r[25:0];
            endcase
            r          = $urandom;
            special_in = (r[2:0] == 3'd0) ? r[4:3] : 2'd0;
            out_ready  = (r[6:5] != 2'b00);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rnd_spurious: got result %h with no beat outstanding", result);
                end else begin
                    e = exp_q.pop_front();
                    if ({result, flags} !== e) begin
                        n_fail++;
                        $display("FAIL rnd_result: got %h/%b want %h/%b", result, flags, e[34:3], e[2:0]);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(sign_in, exp_in, mantis_in, special_in));
        end
        @(negedge clk);
        idle_inputs();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            #1;
            if (out_valid) begin
                n_checks++;
                e = exp_q.pop_front();
                if ({result, flags} !== e) begin
                    n_fail++;
                    $display("FAIL rnd_drain: got %h/%b want %h/%b", result, flags, e[34:3], e[2:0]);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_drain_timeout: got %0d beats left want 0", exp_q.size());
            exp_q.delete();
        end
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [7:0]  b_exp [3];
        logic [25:0] b_man [3];
        logic [34:0] e;
        logic [31:0] held;
        logic [31:0] r;
        int acc = 0;
        for (int k = 0; k < 3; k++) begin
            r        = $urandom;
            b_exp[k] = 8'(r[7:0] % 253) + 8'd1;
            b_man[k] = {1'b1, r[24:0]};
        end
        @(negedge clk);
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            in_valid   = 1'b1;
            sign_in    = 1'b0;
            special_in = 2'd0;
            exp_in     = b_exp[acc];
            mantis_in  = b_man[acc];
            #1;
            if (in_ready) acc++;
            @(negedge clk);
        end
        exp_in    = b_exp[2];
        mantis_in = b_man[2];
        #1;
        n_checks++;
        if (acc != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", acc); end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        held = result;
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || result !== held) begin
            n_fail++;
            $display("FAIL bp_hold: got valid=%b result=%h want valid=1 result=%h", out_valid, result, held);
        end
        @(negedge clk);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            e = model(1'b0, b_exp[k], b_man[k], 2'd0);
            n_checks++;
            if (out_valid !== 1'b1 || {result, flags} !== e) begin
                n_fail++;
                $display("FAIL bp_order%0d: got valid=%b %h/%b want valid=1 %h/%b",
                         k, out_valid, result, flags, e[34:3], e[2:0]);
            end
            if (in_valid && in_ready) acc++;
            @(negedge clk);
            if (acc >= 3) in_valid = 1'b0;
        end
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup: got out_valid=%b want 0", out_valid); end
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        logic [34:0] e;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b1;
        exp_in    = 8'd127;
        mantis_in = 26'h2000006;
        @(negedge clk);
        mantis_in = 26'h3000000;
        @(negedge clk);
        idle_inputs();
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstm_inflight: got %b want 1", out_valid); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || flags !== 3'd0) begin
            n_fail++;
            $display("FAIL rstm_async: got valid=%b %h/%b want 0 00000000/000", out_valid, result, flags);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstm_ghost%0d: got %b want 0", c, out_valid); end
            @(negedge clk);
        end
        in_valid  = 1'b1;
        sign_in   = 1'b1;
        exp_in    = 8'd200;
        mantis_in = 26'h2ABCDEF;
        e         = model(1'b1, 8'd200, 26'h2ABCDEF, 2'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || {result, flags} !== e) begin
            n_fail++;
            $display("FAIL rstm_resume: got valid=%b %h/%b want valid=1 %h/%b",
                     out_valid, result, flags, e[34:3], e[2:0]);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_pressure();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
